// File: rtl/mode_seq_if.sv
// Handshake and mode bundle between the upstream requester and mode_sequencer.
// master = requester/datapath side, slave = sequencer side.
interface mode_seq_if;
  logic [1:0] mode_req;
  logic       req_valid;
  logic       req_ready;
  logic       switch_ok;
  logic [1:0] Mode_input;
  logic       mode_changed;
  logic       busy;
  logic       req_abort;

  modport master (
    output mode_req,
    output req_valid,
    output switch_ok,
    input  req_ready,
    input  Mode_input,
    input  mode_changed,
    input  busy,
    input  req_abort
  );

  modport slave (
    input  mode_req,
    input  req_valid,
    input  switch_ok,
    output req_ready,
    output Mode_input,
    output mode_changed,
    output busy,
    output req_abort
  );
endinterface

// File: rtl/mode_sequencer.sv
// Registered mode controller feeding the one-hot select encoder's Mode_input.
// Optional switch_ok wait timeout is enabled by defining MODE_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; equal-mode requests are silent no-ops
// ST_WAIT   | holding pending mode until downstream reports a safe point
// ST_DWELL  | new mode committed, holding it for DWELL_CYCLES
module mode_sequencer #(
  parameter int DWELL_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  mode_seq_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;

  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535) begin : g_bad_dwell
    $error("mode_sequencer: DWELL_CYCLES out of range 1..65535");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mode_sequencer: TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  r_state;
  logic [1:0]  r_pending;
  logic [1:0]  r_mode;
  logic        r_ready;
  logic        r_busy;
  logic        r_changed;
  logic        r_abort;
  logic [15:0] r_cnt;

  logic w_accept;
  logic w_noop;

  // r_ready is only ever high in ST_IDLE, so it doubles as the accept gate.
  assign w_accept = bus.req_valid && r_ready;
  assign w_noop   = (bus.mode_req == r_mode);

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 2'b00;
      r_mode    <= 2'b00;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_changed <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= 16'd0;
      r_wcnt    <= 16'd0;
    end else begin
      r_changed <= 1'b0;
      r_abort   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_noop) begin
            r_pending <= bus.mode_req;
            r_wcnt    <= 16'd0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A switch point on the timeout edge still wins over the abort.
          if (bus.switch_ok) begin
            r_mode    <= r_pending;
            r_changed <= 1'b1;
            r_cnt     <= DWELL_LOAD;
            r_state   <= ST_DWELL;
          end else if (r_wcnt == TIMEOUT_LAST) begin
            r_abort   <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_wcnt    <= r_wcnt + 16'd1;
          end
        end
        ST_DWELL: begin
          if (r_cnt == 16'd0) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 2'b00;
      r_mode    <= 2'b00;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_changed <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      r_changed <= 1'b0;
      r_abort   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_noop) begin
            r_pending <= bus.mode_req;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.switch_ok) begin
            r_mode    <= r_pending;
            r_changed <= 1'b1;
            r_cnt     <= DWELL_LOAD;
            r_state   <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (r_cnt == 16'd0) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
`endif

  assign bus.req_ready    = r_ready;
  assign bus.Mode_input   = r_mode;
  assign bus.mode_changed = r_changed;
  assign bus.busy         = r_busy;
  assign bus.req_abort    = r_abort;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: scoreboard of expected committed modes plus
// cycle-exact checks of handshake, dwell, reset and (optionally) timeout.
module tb_mode_sequencer;
  localparam int DWELL   = 4;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   n_pulse;
  int   n_push;
  bit   abort_seen;
  logic [1:0] sb_q[$];

  mode_seq_if bus ();

  mode_sequencer #(.DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] m);
    sb_q.push_back(m);
    n_push++;
  endtask

  // Scoreboard: every mode_changed pulse must match the next expected commit.
  always @(negedge clk) begin
    if (bus.req_abort) abort_seen = 1'b1;
    if (bus.mode_changed === 1'b1) begin
      n_pulse++;
      if (sb_q.size() == 0) chk("unexpected_change", {30'd0, bus.Mode_input}, 32'hFFFF)
      ;
      else chk("sb_mode", {30'd0, bus.Mode_input}, {30'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_bad = 0; n_pulse = 0; n_push = 0; abort_seen = 1'b0;
    rst = 1'b1;
    bus.mode_req  = 2'b00;
    bus.req_valid = 1'b0;
    bus.switch_ok = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_mode",  bus.Mode_input,   2'b00);
    chk("rst_ready", bus.req_ready,    1'b1);
    chk("rst_busy",  bus.busy,         1'b0);
    chk("rst_chg",   bus.mode_changed, 1'b0);
    chk("rst_abort", bus.req_abort,    1'b0);
    rst = 1'b0;
    tick();

    // Basic change 00 -> 10 with switch_ok held high
    bus.switch_ok = 1'b1;
    bus.mode_req  = 2'b10;
    bus.req_valid = 1'b1;
    push_exp(2'b10);
    tick();
    bus.req_valid = 1'b0;
    chk("e0_ready", bus.req_ready, 1'b0);
    chk("e0_busy",  bus.busy,      1'b1);
    chk("e0_mode",  bus.Mode_input, 2'b00);
    tick();
    chk("e1_mode",  bus.Mode_input,   2'b10);
    chk("e1_chg",   bus.mode_changed, 1'b1);
    for (int i = 1; i <= DWELL; i++) begin
      tick();
      chk("dwell_ready", bus.req_ready,    (i == DWELL) ? 1'b1 : 1'b0);
      chk("dwell_busy",  bus.busy,         (i == DWELL) ? 1'b0 : 1'b1);
      chk("dwell_chg",   bus.mode_changed, 1'b0);
    end

    // No-op: request the current mode 10
    bus.mode_req  = 2'b10;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("noop_ready", bus.req_ready,    1'b1);
    chk("noop_busy",  bus.busy,         1'b0);
    chk("noop_chg",   bus.mode_changed, 1'b0);
    tick();
    chk("noop_busy2", bus.busy,         1'b0);
    chk("noop_chg2",  bus.mode_changed, 1'b0);
    chk("noop_mode",  bus.Mode_input,   2'b10);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_mode", bus.Mode_input, 2'b00);

    // Wait for switch_ok: request 11, extra request 01 presented while busy
    bus.switch_ok = 1'b0;
    bus.mode_req  = 2'b11;
    bus.req_valid = 1'b1;
    push_exp(2'b11);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        bus.mode_req  = 2'b01;
        bus.req_valid = 1'b1;
      end
      if (i == 7) bus.req_valid = 1'b0;
      tick();
      chk("wait_mode",  bus.Mode_input, 2'b00);
      chk("wait_ready", bus.req_ready,  1'b0);
      chk("wait_busy",  bus.busy,       1'b1);
    end
    bus.switch_ok = 1'b1;
    tick();
    chk("wait_commit", bus.Mode_input,   2'b11);
    chk("wait_chg",    bus.mode_changed, 1'b1);
    tick(); tick();
    chk("dwell_mid_mode", bus.Mode_input, 2'b11);

    // Reset in the middle of dwell
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstd_mode",  bus.Mode_input,   2'b00);
    chk("rstd_ready", bus.req_ready,    1'b1);
    chk("rstd_busy",  bus.busy,         1'b0);
    chk("rstd_chg",   bus.mode_changed, 1'b0);
    tick();
    chk("rstd_chg2",  bus.mode_changed, 1'b0);

    // 00 -> 01 is a real change
    bus.switch_ok = 1'b1;
    bus.mode_req  = 2'b01;
    bus.req_valid = 1'b1;
    push_exp(2'b01);
    tick();
    bus.req_valid = 1'b0;
    chk("r01_busy", bus.busy, 1'b1);
    tick();
    chk("r01_mode", bus.Mode_input,   2'b01);
    chk("r01_chg",  bus.mode_changed, 1'b1);
    for (int i = 1; i <= DWELL; i++) tick();
    chk("r01_ready", bus.req_ready, 1'b1);

`ifdef MODE_SEQ_TIMEOUT_EN
    // Timeout with switch_ok held low
    bus.switch_ok = 1'b0;
    bus.mode_req  = 2'b10;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("to_abort", bus.req_abort,  (i == TIMEOUT) ? 1'b1 : 1'b0);
      chk("to_ready", bus.req_ready,  (i == TIMEOUT) ? 1'b1 : 1'b0);
      chk("to_mode",  bus.Mode_input, 2'b01);
    end
    tick();
    chk("to_abort_end", bus.req_abort, 1'b0);
    chk("to_busy_end",  bus.busy,      1'b0);

    // switch_ok arrives on the timeout edge: commit wins
    bus.mode_req  = 2'b11;
    bus.req_valid = 1'b1;
    push_exp(2'b11);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) tick();
    bus.switch_ok = 1'b1;
    tick();
    chk("race_mode",  bus.Mode_input,   2'b11);
    chk("race_chg",   bus.mode_changed, 1'b1);
    chk("race_abort", bus.req_abort,    1'b0);
    tick();
    chk("race_abort2", bus.req_abort,   1'b0);
    for (int i = 1; i <= DWELL; i++) tick();
`else
    chk("abort_never", {31'd0, abort_seen}, 32'd0);
`endif

    tick();
    chk("sb_empty",   sb_q.size(), 0);
    chk("pulse_count", n_pulse,    n_push);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Registered mode controller that sits directly upstream of the one-hot select encoder and drives its 2-bit `Mode_input`. It accepts mode-change requests over a valid/ready handshake and commits each change only when the downstream datapath reports a safe switch point. After each commit it holds the new mode for a minimum dwell time. The encoder therefore only ever sees clean, glitch-free mode transitions spaced at least `DWELL_CYCLES` apart.

## Interface
- `DWELL_CYCLES`, 16: minimum cycles a committed mode is held before a new request is accepted; legal range 1..65535.
- `TIMEOUT_CYCLES`, 256: maximum cycles spent waiting for `switch_ok`; legal range 1..65535; used only when `MODE_SEQ_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode_req` in 2: requested mode; 2'b00/01/10/11.
- `req_valid` in 1: `mode_req` is valid.
- `req_ready` out 1: sequencer can accept a request.
- `switch_ok` in 1: downstream is at a safe switch point.
- `Mode_input` out 2: committed mode; feeds the encoder.
- `mode_changed` out 1: one-cycle pulse in the cycle `Mode_input` takes its new value.
- `busy` out 1: high in WAIT_SAFE and DWELL.
- `req_abort` out 1: one-cycle pulse when a pending request times out. Tied 0 without `MODE_SEQ_TIMEOUT_EN`.

## Operation
- **Reset values:** state IDLE, `Mode_input`=2'b00, `req_ready`=1, `busy`=0, `mode_changed`=0, `req_abort`=0, pending register=0, counter=0.
- **FSM states:** IDLE, WAIT_SAFE, DWELL. All outputs are registered.
- **IDLE:** `req_ready`=1.
  - On `req_valid && req_ready`, if `mode_req != Mode_input`: latch `mode_req` into pending and go to WAIT_SAFE.
  - If `mode_req == Mode_input` (exact 2-bit compare; 00 and 01 are distinct): accept as a no-op, stay in IDLE, no pulse, no dwell.
- **WAIT_SAFE:** `req_ready`=0, `busy`=1.
  - On a sampled `switch_ok`=1: `Mode_input` <= pending, `mode_changed` <= 1 for one cycle, counter <= `DWELL_CYCLES`-1, go to DWELL.
- **DWELL:** `req_ready`=0, `busy`=1.
  - Counter decrements each cycle.
  - On the edge where counter==0: go to IDLE and set `req_ready` <= 1.
- **Upstream obligation:** `mode_req` is held stable while `req_valid && !req_ready`. The sequencer does not check this.
- **Requests while busy:** `req_valid` is ignored. No queueing, no drop flag.
- **`switch_ok` outside WAIT_SAFE:** ignored.
- **Counter width:** 16 bits, unsigned. It never wraps, because it loads only legal parameter values and stops at 0.

## Timing
- **Accept edge E0:** `req_ready`=0 and `busy`=1 from E0 onward.
- **Minimum commit latency:** 1 cycle. If `switch_ok`=1 is sampled at E1, `Mode_input` and `mode_changed` update at E1.
- **Dwell length:** `req_ready` returns high at E1+`DWELL_CYCLES`. Back-to-back commits are therefore spaced at least `DWELL_CYCLES`+1 cycles apart.
- **`mode_changed`:** high for exactly one cycle per real change. Never asserted for a no-op request.
- **`rst` mid-operation:** at the next edge all state returns to reset values, the pending request is discarded, and `Mode_input` returns to 2'b00. No `mode_changed` pulse for this reset-driven change.

## Configuration
- `MODE_SEQ_TIMEOUT_EN` defined:
  - A 16-bit wait counter clears on entry to WAIT_SAFE and increments each cycle while `switch_ok`=0.
  - On the edge where it reaches `TIMEOUT_CYCLES`: go to IDLE, pulse `req_abort` for one cycle, leave `Mode_input` unchanged, skip the dwell, set `req_ready` <= 1.
  - If `switch_ok`=1 on that same edge, the switch wins: commit and no abort.
- `MODE_SEQ_TIMEOUT_EN` undefined:
  - WAIT_SAFE waits indefinitely for `switch_ok`.
  - `req_abort` is constant 0 and the wait counter logic is absent.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then release. Required: `Mode_input`=00, `req_ready`=1, `busy`=0, with no pulses.
- **Basic change:** hold `switch_ok`=1, send `mode_req`=10 with `DWELL_CYCLES`=4. Required: `Mode_input`=10 one cycle after accept, a single `mode_changed` pulse, and `req_ready` high again 4 cycles after the change.
- **Wait and busy behaviour:** hold `switch_ok` low for 10 cycles after a request for 11, then raise it. Required: `Mode_input` stays 00 for those 10 cycles and changes to 11 on the first cycle `switch_ok` is sampled high. A second request presented during WAIT_SAFE is ignored.
- **No-op:** with `Mode_input`=10, request 10. Required: accepted in one cycle, `busy` stays 0, no `mode_changed`. Then request 01 from 00. Required: treated as a real change.
- **Reset mid-DWELL:** assert `rst` during DWELL with `Mode_input`=11. Required: next edge `Mode_input`=00, `req_ready`=1, `busy`=0.
- **Timeout (with `MODE_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `switch_ok` held 0):** required: `req_abort` pulses 8 cycles after accept, `Mode_input` unchanged, `req_ready`=1. Also raise `switch_ok` exactly on the 8th cycle. Required: commit, with no abort.
